// File: rtl/fifo_data_param.sv
// ============================================================================
// Module   : fifo_data_param
// Brief    : Parametrised first-word-fall-through synchronous FIFO with flush,
//            almost-full/almost-empty thresholds and optional sticky error
//            flags (enabled by macro FIFO_ERR_FLAGS_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_data_param #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 4,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
`ifdef FIFO_ERR_FLAGS_EN
    input  logic              err_clr,
    output logic              overflow,
    output logic              underflow,
`endif
    output logic [$clog2(DEPTH):0] count,
    output logic              empty,
    output logic              full,
    output logic              almost_full,
    output logic              almost_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_C    = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0] AE_C    = (AW+1)'(AE_LEVEL);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              wr_acc;
    logic              rd_acc;
    logic              op_ok;

    // A write into a full FIFO is allowed when the head is popped in the same cycle.
    assign op_ok  = resetn & ~flush;
    assign wr_acc = wr_en & (~full | rd_en) & op_ok;
    assign rd_acc = rd_en & ~empty & op_ok;

    assign empty        = (count == '0);
    assign full         = (count == DEPTH_C);
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);
    assign rd_data      = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_acc && !rd_acc) begin
                count <= count + 1'b1;
            end else if (rd_acc && !wr_acc) begin
                count <= count - 1'b1;
            end
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    // A read that coincides with a write at empty is not an underflow:
    // the requester is served the new word on the following cycle.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && full && !rd_en) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end
            if (rd_en && empty && !wr_en) begin
                underflow <= 1'b1;
            end else if (err_clr) begin
                underflow <= 1'b0;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_data_param.sv
// ============================================================================
// Module   : tb_fifo_data_param
// Brief    : Self-checking bench: directed vector table on a 4x32 FIFO and a
//            randomised scoreboard run on a 16x128 FIFO.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_data_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- DUT A: DEPTH=4, DATA_W=32 ----------------
    logic        a_resetn, a_flush, a_wr_en, a_rd_en, a_err_clr;
    logic [31:0] a_wr_data, a_rd_data;
    logic [2:0]  a_count;
    logic        a_empty, a_full, a_af, a_ae, a_ov, a_uf;

    fifo_data_param #(.DATA_W(32), .DEPTH(4)) dut_a (
        .clk(clk), .resetn(a_resetn), .flush(a_flush),
        .wr_en(a_wr_en), .wr_data(a_wr_data), .rd_en(a_rd_en), .rd_data(a_rd_data),
`ifdef FIFO_ERR_FLAGS_EN
        .err_clr(a_err_clr), .overflow(a_ov), .underflow(a_uf),
`endif
        .count(a_count), .empty(a_empty), .full(a_full),
        .almost_full(a_af), .almost_empty(a_ae)
    );

    // ---------------- DUT B: DEPTH=16, DATA_W=128 ----------------
    logic         b_resetn, b_flush, b_wr_en, b_rd_en, b_err_clr;
    logic [127:0] b_wr_data, b_rd_data;
    logic [4:0]   b_count;
    logic         b_empty, b_full, b_af, b_ae, b_ov, b_uf;

    fifo_data_param #(.DATA_W(128), .DEPTH(16), .AF_LEVEL(12), .AE_LEVEL(2)) dut_b (
        .clk(clk), .resetn(b_resetn), .flush(b_flush),
        .wr_en(b_wr_en), .wr_data(b_wr_data), .rd_en(b_rd_en), .rd_data(b_rd_data),
`ifdef FIFO_ERR_FLAGS_EN
        .err_clr(b_err_clr), .overflow(b_ov), .underflow(b_uf),
`endif
        .count(b_count), .empty(b_empty), .full(b_full),
        .almost_full(b_af), .almost_empty(b_ae)
    );

`ifndef FIFO_ERR_FLAGS_EN
    assign a_ov = 1'b0;
    assign a_uf = 1'b0;
    assign b_ov = 1'b0;
    assign b_uf = 1'b0;
`endif

    typedef struct {
        logic        rstn, fl, wr, rd, clr;
        logic [31:0] wd;
        logic [2:0]  cnt;
        logic        e, f, af, ae, ov, uf, vld;
        logic [31:0] rdd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rstn, logic fl, logic wr, logic rd, logic clr,
                                logic [31:0] wd, logic [2:0] cnt, logic ov, logic uf,
                                logic vld, logic [31:0] rdd);
        vec_t v;
        v.rstn = rstn; v.fl = fl; v.wr = wr; v.rd = rd; v.clr = clr; v.wd = wd;
        v.cnt = cnt; v.ov = ov; v.uf = uf; v.vld = vld; v.rdd = rdd;
        // Flags follow directly from the DEPTH=4, AF=3, AE=1 thresholds.
        v.e  = (cnt == 0);
        v.f  = (cnt == 4);
        v.af = (cnt >= 3);
        v.ae = (cnt <= 1);
        return v;
    endfunction

    // Scoreboard model for DUT B
    logic [127:0] mq[$];
    logic         m_ov, m_uf;

    initial begin
        a_resetn = 0; a_flush = 0; a_wr_en = 0; a_rd_en = 0; a_err_clr = 0; a_wr_data = '0;
        b_resetn = 0; b_flush = 0; b_wr_en = 0; b_rd_en = 0; b_err_clr = 0; b_wr_data = '0;
        m_ov = 0; m_uf = 0;

        //            rstn fl wr rd clr data   cnt ov uf vld rdd
        vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,  0, 0, 0, 0, 32'h0));   // reset
        vecs.push_back(mk(1, 0, 1, 0, 0, 32'hA0, 1, 0, 0, 1, 32'hA0));  // fill
        vecs.push_back(mk(1, 0, 1, 0, 0, 32'hA1, 2, 0, 0, 1, 32'hA0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 32'hA2, 3, 0, 0, 1, 32'hA0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 32'hA3, 4, 0, 0, 1, 32'hA0));
        vecs.push_back(mk(1, 0, 1, 1, 0, 32'hA4, 4, 0, 0, 1, 32'hA1));  // wr+rd at full
        vecs.push_back(mk(1, 0, 0, 1, 0, 32'h0,  3, 0, 0, 1, 32'hA2));  // drain, wrap
        vecs.push_back(mk(1, 0, 0, 1, 0, 32'h0,  2, 0, 0, 1, 32'hA3));
        vecs.push_back(mk(1, 0, 0, 1, 0, 32'h0,  1, 0, 0, 1, 32'hA4));
        vecs.push_back(mk(1, 0, 0, 1, 0, 32'h0,  0, 0, 0, 0, 32'h0));
        vecs.push_back(mk(1, 0, 1, 1, 0, 32'h55, 1, 0, 0, 1, 32'h55));  // wr+rd at empty
        vecs.push_back(mk(1, 0, 1, 0, 0, 32'h01, 2, 0, 0, 1, 32'h55));
        vecs.push_back(mk(1, 0, 1, 0, 0, 32'h02, 3, 0, 0, 1, 32'h55));
        vecs.push_back(mk(1, 1, 1, 0, 0, 32'h77, 0, 0, 0, 0, 32'h0));   // flush beats write
        vecs.push_back(mk(1, 0, 1, 0, 0, 32'h88, 1, 0, 0, 1, 32'h88));
        vecs.push_back(mk(1, 0, 0, 1, 0, 32'h0,  0, 0, 0, 0, 32'h0));
        vecs.push_back(mk(1, 0, 0, 1, 0, 32'h0,  0, 0, 1, 0, 32'h0));   // read while empty
        vecs.push_back(mk(1, 0, 1, 0, 0, 32'hB0, 1, 0, 1, 1, 32'hB0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 32'hB1, 2, 0, 1, 1, 32'hB0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 32'hB2, 3, 0, 1, 1, 32'hB0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 32'hB3, 4, 0, 1, 1, 32'hB0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 32'hB4, 4, 1, 1, 1, 32'hB0));  // write while full
        vecs.push_back(mk(1, 0, 0, 0, 1, 32'h0,  4, 0, 0, 1, 32'hB0));  // err_clr
        vecs.push_back(mk(1, 0, 1, 0, 1, 32'hB5, 4, 1, 0, 1, 32'hB0));  // set beats clear
        vecs.push_back(mk(1, 0, 0, 1, 0, 32'h0,  3, 1, 0, 1, 32'hB1));
        vecs.push_back(mk(0, 0, 1, 0, 0, 32'hCC, 0, 0, 0, 0, 32'h0));   // mid-op reset
        vecs.push_back(mk(1, 0, 1, 0, 0, 32'hC0, 1, 0, 0, 1, 32'hC0));

        foreach (vecs[i]) begin
            @(negedge clk);
            a_resetn = vecs[i].rstn; a_flush = vecs[i].fl; a_wr_en = vecs[i].wr;
            a_rd_en = vecs[i].rd; a_err_clr = vecs[i].clr; a_wr_data = vecs[i].wd;
            @(posedge clk);
            #1;
            chk($sformatf("a%0d_count", i), 128'(a_count), 128'(vecs[i].cnt));
            chk($sformatf("a%0d_empty", i), 128'(a_empty), 128'(vecs[i].e));
            chk($sformatf("a%0d_full", i),  128'(a_full),  128'(vecs[i].f));
            chk($sformatf("a%0d_af", i),    128'(a_af),    128'(vecs[i].af));
            chk($sformatf("a%0d_ae", i),    128'(a_ae),    128'(vecs[i].ae));
            if (vecs[i].vld)
                chk($sformatf("a%0d_rd_data", i), 128'(a_rd_data), 128'(vecs[i].rdd));
`ifdef FIFO_ERR_FLAGS_EN
            chk($sformatf("a%0d_overflow", i),  128'(a_ov), 128'(vecs[i].ov));
            chk($sformatf("a%0d_underflow", i), 128'(a_uf), 128'(vecs[i].uf));
`endif
        end

        // Randomised scoreboard run on the wide, deep instance.
        @(negedge clk);
        b_resetn = 0;
        @(posedge clk);
        #1;
        mq.delete();
        for (int cyc = 0; cyc < 10000; cyc++) begin
            logic wacc, racc, full_m, empty_m;
            @(negedge clk);
            b_resetn  = !(cyc == 5000 || cyc == 5001);
            b_flush   = ($urandom_range(0, 99) == 0);
            b_wr_en   = ($urandom_range(0, 99) < ((cyc / 1000) % 2 ? 70 : 35));
            b_rd_en   = ($urandom_range(0, 99) < 50);
            b_err_clr = ($urandom_range(0, 31) == 0);
            b_wr_data = {$urandom, $urandom, $urandom, $urandom};
            full_m  = (mq.size() == 16);
            empty_m = (mq.size() == 0);
            wacc = b_wr_en && (!full_m || b_rd_en);
            racc = b_rd_en && !empty_m;
            if (!b_resetn) begin
                m_ov = 0; m_uf = 0;
            end else begin
                if (b_wr_en && full_m && !b_rd_en) m_ov = 1;
                else if (b_err_clr)                m_ov = 0;
                if (b_rd_en && empty_m && !b_wr_en) m_uf = 1;
                else if (b_err_clr)                 m_uf = 0;
            end
            if (!b_resetn || b_flush) begin
                mq.delete();
            end else begin
                if (racc) void'(mq.pop_front());
                if (wacc) mq.push_back(b_wr_data);
            end
            @(posedge clk);
            #1;
            chk("b_count", 128'(b_count), 128'(mq.size()));
            chk("b_empty", 128'(b_empty), 128'(mq.size() == 0));
            chk("b_full",  128'(b_full),  128'(mq.size() == 16));
            chk("b_af",    128'(b_af),    128'(mq.size() >= 12));
            chk("b_ae",    128'(b_ae),    128'(mq.size() <= 2));
            if (mq.size() != 0)
                chk("b_rd_data", b_rd_data, mq[0]);
`ifdef FIFO_ERR_FLAGS_EN
            chk("b_overflow",  128'(b_ov), 128'(m_ov));
            chk("b_underflow", 128'(b_uf), 128'(m_uf));
`endif
            if (cyc == 5000) begin
                chk("b_rst_count", 128'(b_count), 128'(0));
                chk("b_rst_empty", 128'(b_empty), 128'(1));
                chk("b_rst_ae",    128'(b_ae),    128'(1));
                chk("b_rst_af",    128'(b_af),    128'(0));
                chk("b_rst_flags", 128'({b_ov, b_uf}), 128'(0));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
